// File: rtl/cpu_reset_sequencer.sv
// CPU bring-up reset sequencer: waits for a stable PLL lock, holds the CPU
// in reset for a fixed window, then releases it on a clock edge. Button
// pulses and lock loss re-run the sequence. Also drives bring-up LEDs,
// a RUN heartbeat and a saturating re-sequence counter.
module cpu_reset_sequencer #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int HOLD_CYCLES        = 16,
  parameter int HEARTBEAT_DIV      = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       reset_button,
  output logic       cpu_rst,
  output logic [1:0] state_leds,
  output logic       heartbeat,
  output logic [7:0] reset_count
);

  localparam int MAXC = (LOCK_STABLE_CYCLES > HOLD_CYCLES) ? LOCK_STABLE_CYCLES : HOLD_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int DW   = (HEARTBEAT_DIV > 1) ? $clog2(HEARTBEAT_DIV) : 1;

  localparam logic [CW-1:0] STAB_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [DW-1:0] HB_LAST   = DW'(HEARTBEAT_DIV - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'b00,
    STABILIZE = 2'b01,
    HOLD      = 2'b10,
    RUN       = 2'b11
  } state_t;

  state_t          state, next_state;
  logic [1:0]      sync_ff;
  logic            locked_s;
  logic [CW-1:0]   cnt;
  logic            cnt_clr, cnt_inc, reseq;
  logic [DW-1:0]   hb_div;

  assign locked_s   = sync_ff[1];
  assign state_leds = state;

  // Two-flop synchronizer for the asynchronous PLL lock flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_ff <= 2'b00;
    else      sync_ff <= {sync_ff[0], pll_locked};
  end

  // Next-state and counter control; lock loss always wins over the button
  always_comb begin
    next_state = state;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    reseq      = 1'b0;
    case (state)
      WAIT_LOCK: begin
        if (locked_s) next_state = STABILIZE;
      end
      STABILIZE: begin
        if (!locked_s)              next_state = WAIT_LOCK;
        else if (cnt == STAB_LAST)  next_state = HOLD;
        else                        cnt_inc    = 1'b1;
      end
      HOLD: begin
        if (!locked_s)              next_state = WAIT_LOCK;
        else if (reset_button)      cnt_clr    = 1'b1;
        else if (cnt == HOLD_LAST)  next_state = RUN;
        else                        cnt_inc    = 1'b1;
      end
      RUN: begin
        if (!locked_s) begin
          next_state = WAIT_LOCK;
          reseq      = 1'b1;
        end else if (reset_button) begin
          next_state = HOLD;
          reseq      = 1'b1;
        end
      end
      default: next_state = WAIT_LOCK;
    endcase
  end

  // State register and registered CPU reset derived from the next state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= WAIT_LOCK;
      cpu_rst <= 1'b1;
    end else begin
      state   <= next_state;
      cpu_rst <= (next_state != RUN);
    end
  end

  // Shared window counter, cleared on any transition or a HOLD restart
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                              cnt <= '0;
    else if (next_state != state || cnt_clr) cnt <= '0;
    else if (cnt_inc)                      cnt <= cnt + 1'b1;
  end

  // Heartbeat divider runs only in RUN and is cleared on the way out
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hb_div    <= '0;
      heartbeat <= 1'b0;
    end else if (next_state != RUN) begin
      hb_div    <= '0;
      heartbeat <= 1'b0;
    end else if (state == RUN) begin
      if (hb_div == HB_LAST) begin
        hb_div    <= '0;
        heartbeat <= ~heartbeat;
      end else begin
        hb_div    <= hb_div + 1'b1;
      end
    end
  end

  // Saturating count of re-sequence events out of RUN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                reset_count <= 8'd0;
    else if (reseq && reset_count != 8'hFF)  reset_count <= reset_count + 8'd1;
  end

endmodule

// File: tb/tb_cpu_reset_sequencer.sv
// Directed bench for cpu_reset_sequencer with L=4, H=3, DIV=5.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_cpu_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       reset_button;
  logic       cpu_rst;
  logic [1:0] state_leds;
  logic       heartbeat;
  logic [7:0] reset_count;

  int checks = 0;
  int errors = 0;

  cpu_reset_sequencer #(
    .LOCK_STABLE_CYCLES(4),
    .HOLD_CYCLES(3),
    .HEARTBEAT_DIV(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pll_locked(pll_locked),
    .reset_button(reset_button),
    .cpu_rst(cpu_rst),
    .state_leds(state_leds),
    .heartbeat(heartbeat),
    .reset_count(reset_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; pll_locked = 1'b1; reset_button = 1'b0;
    step(2);
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_leds", state_leds, 0);
    chk("rst_hb", heartbeat, 0);
    chk("rst_count", reset_count, 0);

    // Release: edge 3 STABILIZE, edge 7 HOLD, edge 10 RUN
    rst = 1'b1;
    step(2);  chk("e2_leds", state_leds, 0);
    step(1);  chk("e3_leds", state_leds, 1);
    step(3);  chk("e6_leds", state_leds, 1);
    step(1);  chk("e7_leds", state_leds, 2);
    step(2);  chk("e9_leds", state_leds, 2);
              chk("e9_cpu_rst", cpu_rst, 1);
    step(1);  chk("e10_leds", state_leds, 3);
              chk("e10_cpu_rst", cpu_rst, 0);
              chk("e10_count", reset_count, 0);

    // Heartbeat toggles 5 cycles after RUN entry
    step(4);  chk("hb_e14", heartbeat, 0);
    step(1);  chk("hb_e15", heartbeat, 1);
    step(3);  chk("hb_e18", heartbeat, 1);

    // Button in RUN while heartbeat high: HOLD for exactly 3 cycles
    reset_button = 1'b1;
    step(1);  reset_button = 1'b0;
              chk("btn_leds", state_leds, 2);
              chk("btn_cpu_rst", cpu_rst, 1);
              chk("btn_count", reset_count, 1);
              chk("btn_hb_clr", heartbeat, 0);
    step(2);  chk("btn_hold3", state_leds, 2);
    step(1);  chk("btn_run", state_leds, 3);
              chk("btn_run_rst", cpu_rst, 0);

    // Button in HOLD at cnt=2 restarts the window
    reset_button = 1'b1;
    step(1);  reset_button = 1'b0;       // edge 23: HOLD cnt0
              chk("h_count2", reset_count, 2);
    step(2);                             // edge 25: cnt2
    reset_button = 1'b1;
    step(1);  reset_button = 1'b0;       // edge 26: restart
              chk("h_restart_leds", state_leds, 2);
              chk("h_restart_count", reset_count, 2);
    step(2);  chk("h_e28_leds", state_leds, 2);
              chk("h_e28_rst", cpu_rst, 1);
    step(1);  chk("h_e29_leds", state_leds, 3);
              chk("h_e29_rst", cpu_rst, 0);

    // Lock loss and button coincide at the FSM: counted once
    pll_locked = 1'b0;
    step(2);  chk("sim_still_run", state_leds, 3);
    reset_button = 1'b1;
    step(1);  reset_button = 1'b0; pll_locked = 1'b1;
              chk("sim_leds", state_leds, 0);
              chk("sim_count", reset_count, 3);
              chk("sim_cpu_rst", cpu_rst, 1);
              chk("sim_hb", heartbeat, 0);

    // One-cycle lock glitch during STABILIZE
    step(3);  chk("g_stab", state_leds, 1);   // edge 35
    pll_locked = 1'b0;
    step(1);  pll_locked = 1'b1;
    step(1);  chk("g_e37_leds", state_leds, 1);
    step(1);  chk("g_e38_leds", state_leds, 0);
              chk("g_e38_rst", cpu_rst, 1);
    step(1);  chk("g_e39_leds", state_leds, 1);
    step(3);  chk("g_e42_leds", state_leds, 1);
              chk("g_e42_rst", cpu_rst, 1);
    step(1);  chk("g_e43_leds", state_leds, 2);
    step(2);  chk("g_e45_rst", cpu_rst, 1);
    step(1);  chk("g_e46_leds", state_leds, 3);
              chk("g_e46_rst", cpu_rst, 0);
              chk("g_count", reset_count, 3);

    // 300 button pulses saturate the counter
    for (int i = 0; i < 300; i++) begin
      reset_button = 1'b1;
      step(1);  reset_button = 1'b0;
      step(3);
    end
    chk("sat_count", reset_count, 255);
    chk("sat_leds", state_leds, 3);

    // Asynchronous reset mid-HOLD
    reset_button = 1'b1;
    step(1);  reset_button = 1'b0;
    step(1);  chk("mid_hold", state_leds, 2);
    #2 rst = 1'b0;
    #1;
    chk("arst_cpu_rst", cpu_rst, 1);
    chk("arst_leds", state_leds, 0);
    chk("arst_count", reset_count, 0);
    chk("arst_hb", heartbeat, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
